// File: rtl/weight_medium_pkg.sv
// Shared types for the weight BRAM arbiter: FSM encoding, grant identifiers and the request record.
package weight_medium_pkg;

  localparam int WM_WEIGHT_LENGTH = 256;
  localparam int WM_A_SIZE        = $clog2(WM_WEIGHT_LENGTH);
  localparam int WM_W_SIZE        = 1024;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_READ_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE      = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    READ_WAIT = ST_READ_WAIT,
    DONE      = ST_DONE
  } wm_state_t;

  typedef enum logic {
    GRANT_CPU  = 1'b0,
    GRANT_HOST = 1'b1
  } wm_grant_t;

  // Sized for the shipped weight store; the top derives its port widths from the same constants.
  typedef struct packed {
    logic [WM_A_SIZE-1:0] addr;
    logic [WM_W_SIZE-1:0] data;
    logic                 we;
  } wm_req_t;

endpackage

// File: rtl/weight_medium_arbiter_rr.sv
// Two-way round-robin pick: on a tie the requester that did not win last time is granted.
module rr_arbiter_2
  import weight_medium_pkg::*;
(
  input  logic [1:0] req,
  input  wm_grant_t  last_grant,
  output wm_grant_t  grant,
  output logic       grant_valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    grant       = GRANT_CPU;
    grant_valid = |req;
    if (req == 2'b11) begin
      grant = (last_grant == GRANT_CPU) ? GRANT_HOST : GRANT_CPU;
    end else if (req[1]) begin
      grant = GRANT_HOST;
    end
  end

endmodule

// File: rtl/weight_medium_arbiter.sv
// Shares the single-port weight BRAM between the cpu pulse port and the host valid/ready port,
// one buffered request per side, round-robin granted, with a latency counter for reads.
module weight_medium_arbiter
  import weight_medium_pkg::*;
#(
  parameter  int WEIGHT_LENGTH = WM_WEIGHT_LENGTH,
  parameter  int W_SIZE        = WM_W_SIZE,
  parameter  int BRAM_LATENCY  = 2,
  localparam int A_SIZE        = $clog2(WEIGHT_LENGTH)
)(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [A_SIZE-1:0] cpu_addr_in,
  input  logic [W_SIZE-1:0] cpu_data_in,
  input  logic              cpu_read_enable_in,
  input  logic              cpu_write_enable_in,
  output logic [W_SIZE-1:0] cpu_data_out,
  output logic              cpu_finished_out,
  input  logic              host_valid_in,
  input  logic              host_we_in,
  input  logic [A_SIZE-1:0] host_addr_in,
  input  logic [W_SIZE-1:0] host_data_in,
  output logic              host_ready_out,
  output logic [W_SIZE-1:0] host_data_out,
  output logic              host_done_out,
  output logic              bram_en_out,
  output logic              bram_we_out,
  output logic [A_SIZE-1:0] bram_addr_out,
  output logic [W_SIZE-1:0] bram_din_out,
  input  logic [W_SIZE-1:0] bram_dout_in,
  output logic              error_out
);

  localparam int                CW         = $clog2(BRAM_LATENCY + 1);
  localparam logic [A_SIZE:0]   ADDR_LIMIT = (A_SIZE + 1)'(WEIGHT_LENGTH);

  wm_state_t         state;
  wm_grant_t         grant_q;
  wm_grant_t         last_grant;
  wm_grant_t         arb_grant;
  logic              arb_valid;
  logic [CW-1:0]     lat_cnt;
  wm_req_t           cpu_buf;
  wm_req_t           host_buf;
  wm_req_t           sel_req;
  logic              cpu_pending;
  logic              host_pending;
  logic              cpu_pulse;
  logic              host_accept;
  logic              sel_in_range;

  assign cpu_pulse    = cpu_read_enable_in | cpu_write_enable_in;
  assign host_accept  = host_valid_in & host_ready_out;
  assign sel_req      = (arb_grant == GRANT_CPU) ? cpu_buf : host_buf;
  // Non-power-of-2 stores leave a hole at the top of the address space that must never reach the BRAM.
  assign sel_in_range = ({1'b0, sel_req.addr} < ADDR_LIMIT);

  rr_arbiter_2 u_rr (
    .req         ({host_pending, cpu_pending}),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // NOTE: the payload registers carry no reset; the pending flags alone say whether a buffer is live.
  always_ff @(posedge clk_in) begin
    if (cpu_pulse && !cpu_pending) begin
      cpu_buf.addr <= cpu_addr_in;
      cpu_buf.data <= cpu_data_in;
      cpu_buf.we   <= cpu_write_enable_in;
    end
    if (host_accept) begin
      host_buf.addr <= host_addr_in;
      host_buf.data <= host_data_in;
      host_buf.we   <= host_we_in;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      grant_q          <= GRANT_CPU;
      last_grant       <= GRANT_HOST;
      lat_cnt          <= '0;
      cpu_pending      <= 1'b0;
      host_pending     <= 1'b0;
      host_ready_out   <= 1'b1;
      error_out        <= 1'b0;
      bram_en_out      <= 1'b0;
      bram_we_out      <= 1'b0;
      bram_addr_out    <= '0;
      bram_din_out     <= '0;
      cpu_finished_out <= 1'b0;
      host_done_out    <= 1'b0;
      cpu_data_out     <= '0;
      host_data_out    <= '0;
    end else begin
      bram_en_out      <= 1'b0;
      bram_we_out      <= 1'b0;
      cpu_finished_out <= 1'b0;
      host_done_out    <= 1'b0;

      // A cpu pulse cannot be back-pressured, so overlap or a read+write pulse is flagged instead.
      if (cpu_pulse) begin
        if (cpu_pending || (cpu_read_enable_in && cpu_write_enable_in)) error_out <= 1'b1;
        if (!cpu_pending) cpu_pending <= 1'b1;
      end

      if (host_accept) begin
        host_pending   <= 1'b1;
        host_ready_out <= 1'b0;
      end else begin
        host_ready_out <= !host_pending;
      end

      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_q       <= arb_grant;
            last_grant    <= arb_grant;
            bram_addr_out <= sel_req.addr;
            bram_din_out  <= sel_req.data;
            bram_en_out   <= sel_in_range;
            bram_we_out   <= sel_in_range & sel_req.we;
            if (sel_req.we || !sel_in_range) begin
              state <= DONE;
              if (!sel_req.we) begin
                if (arb_grant == GRANT_CPU) cpu_data_out  <= '0;
                else                        host_data_out <= '0;
              end
            end else begin
              state   <= READ_WAIT;
              lat_cnt <= CW'(BRAM_LATENCY - 1);
            end
          end
        end
        READ_WAIT: begin
          if (lat_cnt == '0) begin
            if (grant_q == GRANT_CPU) cpu_data_out  <= bram_dout_in;
            else                      host_data_out <= bram_dout_in;
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end
        DONE: begin
          if (grant_q == GRANT_CPU) begin
            cpu_finished_out <= 1'b1;
            cpu_pending      <= 1'b0;
          end else begin
            host_done_out <= 1'b1;
            host_pending  <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_medium_arbiter.sv
// Directed bench for weight_medium_arbiter with a one-cycle registered BRAM model (BRAM_LATENCY=2).
module tb_weight_medium_arbiter;

  localparam logic [1023:0] PAT_A5 = {128{8'hA5}};
  localparam logic [1023:0] PAT_B  = {64{16'h1234}};
  localparam logic [1023:0] PAT_C  = {32{32'hDEADBEEF}};
  localparam logic [1023:0] PAT_D  = {128{8'h3C}};

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [7:0]    cpu_addr_in;
  logic [1023:0] cpu_data_in;
  logic          cpu_read_enable_in, cpu_write_enable_in;
  logic [1023:0] cpu_data_out;
  logic          cpu_finished_out;
  logic          host_valid_in, host_we_in;
  logic [7:0]    host_addr_in;
  logic [1023:0] host_data_in;
  logic          host_ready_out;
  logic [1023:0] host_data_out;
  logic          host_done_out;
  logic          bram_en_out, bram_we_out;
  logic [7:0]    bram_addr_out;
  logic [1023:0] bram_din_out;
  logic [1023:0] bram_dout_in;
  logic          error_out;

  // Second instance with a non-power-of-2 store, constant BRAM data.
  logic [7:0]    d2_cpu_addr = '0;
  logic [1023:0] d2_cpu_data = '0;
  logic          d2_cpu_rd = 1'b0, d2_cpu_wr = 1'b0;
  logic [1023:0] d2_cpu_dout;
  logic          d2_cpu_fin;
  logic          d2_host_valid, d2_host_we;
  logic [7:0]    d2_host_addr;
  logic [1023:0] d2_host_din = '0;
  logic          d2_host_ready;
  logic [1023:0] d2_host_dout;
  logic          d2_host_done;
  logic          d2_en, d2_we;
  logic [7:0]    d2_addr;
  logic [1023:0] d2_din;
  logic [1023:0] d2_bram_dout = '1;
  logic          d2_err;

  logic [1023:0] mem [0:255];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (bram_en_out) begin
      if (bram_we_out) mem[bram_addr_out] <= bram_din_out;
      else             bram_dout_in       <= mem[bram_addr_out];
    end
  end

  weight_medium_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
    .cpu_read_enable_in(cpu_read_enable_in), .cpu_write_enable_in(cpu_write_enable_in),
    .cpu_data_out(cpu_data_out), .cpu_finished_out(cpu_finished_out),
    .host_valid_in(host_valid_in), .host_we_in(host_we_in),
    .host_addr_in(host_addr_in), .host_data_in(host_data_in),
    .host_ready_out(host_ready_out), .host_data_out(host_data_out), .host_done_out(host_done_out),
    .bram_en_out(bram_en_out), .bram_we_out(bram_we_out), .bram_addr_out(bram_addr_out),
    .bram_din_out(bram_din_out), .bram_dout_in(bram_dout_in), .error_out(error_out)
  );

  weight_medium_arbiter #(.WEIGHT_LENGTH(200)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in),
    .cpu_addr_in(d2_cpu_addr), .cpu_data_in(d2_cpu_data),
    .cpu_read_enable_in(d2_cpu_rd), .cpu_write_enable_in(d2_cpu_wr),
    .cpu_data_out(d2_cpu_dout), .cpu_finished_out(d2_cpu_fin),
    .host_valid_in(d2_host_valid), .host_we_in(d2_host_we),
    .host_addr_in(d2_host_addr), .host_data_in(d2_host_din),
    .host_ready_out(d2_host_ready), .host_data_out(d2_host_dout), .host_done_out(d2_host_done),
    .bram_en_out(d2_en), .bram_we_out(d2_we), .bram_addr_out(d2_addr),
    .bram_din_out(d2_din), .bram_dout_in(d2_bram_dout), .error_out(d2_err)
  );

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    cpu_addr_in = '0; cpu_data_in = '0; cpu_read_enable_in = 0; cpu_write_enable_in = 0;
    host_valid_in = 0; host_we_in = 0; host_addr_in = '0; host_data_in = '0;
    d2_host_valid = 0; d2_host_we = 0; d2_host_addr = '0;
    rst_in = 1;
    tick; tick;
    rst_in = 0;
  endtask

  // Issues one cpu write and returns in the cycle its finished pulse is visible.
  task automatic cpu_write(input logic [7:0] a, input logic [1023:0] d);
    bit seen = 0;
    cpu_addr_in = a; cpu_data_in = d; cpu_write_enable_in = 1;
    tick;
    cpu_write_enable_in = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick;
      if (cpu_finished_out) seen = 1;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL cpu_write_timeout addr=%0d: got no finished, want finished", a); end
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp += 10;
    if (bram_en_out !== 1'b0)      begin n_bad++; $display("FAIL rst_en: got %b want 0", bram_en_out); end
    if (bram_we_out !== 1'b0)      begin n_bad++; $display("FAIL rst_we: got %b want 0", bram_we_out); end
    if (bram_addr_out !== 8'd0)    begin n_bad++; $display("FAIL rst_addr: got %0h want 0", bram_addr_out); end
    if (bram_din_out !== '0)       begin n_bad++; $display("FAIL rst_din: got nonzero want 0"); end
    if (cpu_finished_out !== 1'b0) begin n_bad++; $display("FAIL rst_fin: got %b want 0", cpu_finished_out); end
    if (host_done_out !== 1'b0)    begin n_bad++; $display("FAIL rst_done: got %b want 0", host_done_out); end
    if (cpu_data_out !== '0)       begin n_bad++; $display("FAIL rst_cpu_data: got nonzero want 0"); end
    if (host_data_out !== '0)      begin n_bad++; $display("FAIL rst_host_data: got nonzero want 0"); end
    if (host_ready_out !== 1'b1)   begin n_bad++; $display("FAIL rst_ready: got %b want 1", host_ready_out); end
    if (error_out !== 1'b0)        begin n_bad++; $display("FAIL rst_error: got %b want 0", error_out); end
  endtask

  task automatic test_cpu_write_read;
    do_reset;
    cpu_addr_in = 8'd5; cpu_data_in = PAT_A5; cpu_write_enable_in = 1;
    tick;
    cpu_write_enable_in = 0;
    for (int k = 0; k < 4; k++) begin
      n_cmp += 2;
      if (bram_we_out !== (k == 1)) begin n_bad++; $display("FAIL wr_we k=%0d: got %b want %b", k, bram_we_out, k == 1); end
      if (cpu_finished_out !== (k == 2)) begin n_bad++; $display("FAIL wr_fin k=%0d: got %b want %b", k, cpu_finished_out, k == 2); end
      if (k == 1) begin
        n_cmp += 2;
        if (bram_addr_out !== 8'd5) begin n_bad++; $display("FAIL wr_addr: got %0d want 5", bram_addr_out); end
        if (bram_din_out !== PAT_A5) begin n_bad++; $display("FAIL wr_din: got %0h want %0h", bram_din_out[31:0], PAT_A5[31:0]); end
      end
      tick;
    end
    cpu_addr_in = 8'd5; cpu_read_enable_in = 1;
    tick;
    cpu_read_enable_in = 0;
    for (int k = 0; k < 6; k++) begin
      n_cmp += 2;
      if (bram_en_out !== (k == 1)) begin n_bad++; $display("FAIL rd_en k=%0d: got %b want %b", k, bram_en_out, k == 1); end
      if (cpu_finished_out !== (k == 4)) begin n_bad++; $display("FAIL rd_fin k=%0d: got %b want %b", k, cpu_finished_out, k == 4); end
      if (k == 1) begin
        n_cmp++;
        if (bram_we_out !== 1'b0) begin n_bad++; $display("FAIL rd_we: got %b want 0", bram_we_out); end
      end
      if (k == 4) begin
        n_cmp++;
        if (cpu_data_out !== PAT_A5) begin n_bad++; $display("FAIL rd_data: got %0h want %0h", cpu_data_out[31:0], PAT_A5[31:0]); end
      end
      tick;
    end
  endtask

  task automatic test_simultaneous;
    do_reset;
    cpu_write(8'd10, PAT_B);
    cpu_write(8'd20, PAT_C);
    do_reset;
    cpu_addr_in = 8'd10; cpu_read_enable_in = 1;
    host_addr_in = 8'd20; host_we_in = 0; host_valid_in = 1;
    tick;
    cpu_read_enable_in = 0; host_valid_in = 0;
    for (int k = 0; k < 10; k++) begin
      n_cmp += 4;
      if (cpu_finished_out !== (k == 4)) begin n_bad++; $display("FAIL sim_fin k=%0d: got %b want %b", k, cpu_finished_out, k == 4); end
      if (host_done_out !== (k == 8)) begin n_bad++; $display("FAIL sim_done k=%0d: got %b want %b", k, host_done_out, k == 8); end
      if (host_ready_out !== (k == 9)) begin n_bad++; $display("FAIL sim_ready k=%0d: got %b want %b", k, host_ready_out, k == 9); end
      if (bram_en_out !== (k == 1 || k == 5)) begin n_bad++; $display("FAIL sim_en k=%0d: got %b want %b", k, bram_en_out, k == 1 || k == 5); end
      if (k == 1 || k == 5) begin
        n_cmp++;
        if (bram_addr_out !== ((k == 1) ? 8'd10 : 8'd20)) begin n_bad++; $display("FAIL sim_addr k=%0d: got %0d want %0d", k, bram_addr_out, (k == 1) ? 10 : 20); end
      end
      if (k == 4) begin
        n_cmp++;
        if (cpu_data_out !== PAT_B) begin n_bad++; $display("FAIL sim_cpu_data: got %0h want %0h", cpu_data_out[31:0], PAT_B[31:0]); end
      end
      if (k == 8) begin
        n_cmp++;
        if (host_data_out !== PAT_C) begin n_bad++; $display("FAIL sim_host_data: got %0h want %0h", host_data_out[31:0], PAT_C[31:0]); end
      end
      tick;
    end
  endtask

  task automatic test_rr_tie;
    logic [7:0] first_addr [2];
    int got = 0;
    do_reset;
    cpu_write(8'd40, PAT_B);
    cpu_addr_in = 8'd41; cpu_data_in = PAT_C; cpu_write_enable_in = 1;
    host_addr_in = 8'd42; host_data_in = PAT_D; host_we_in = 1; host_valid_in = 1;
    tick;
    cpu_write_enable_in = 0; host_valid_in = 0;
    for (int k = 0; k < 12 && got < 2; k++) begin
      if (bram_en_out) begin first_addr[got] = bram_addr_out; got++; end
      tick;
    end
    n_cmp++;
    if (got != 2) begin n_bad++; $display("FAIL tie_count: got %0d accesses want 2", got); end
    else begin
      n_cmp += 2;
      if (first_addr[0] !== 8'd42) begin n_bad++; $display("FAIL tie_first: got addr %0d want 42", first_addr[0]); end
      if (first_addr[1] !== 8'd41) begin n_bad++; $display("FAIL tie_second: got addr %0d want 41", first_addr[1]); end
    end
  endtask

  task automatic test_back_to_back;
    bit seq [8];
    int got = 0;
    bit fire_h;
    do_reset;
    cpu_addr_in = 8'd30; cpu_data_in = PAT_B; cpu_write_enable_in = 1;
    host_addr_in = 8'd60; host_data_in = PAT_C; host_we_in = 1; host_valid_in = 1;
    for (int c = 0; c < 200 && got < 8; c++) begin
      fire_h = host_valid_in && host_ready_out;
      tick;
      cpu_write_enable_in = 0;
      if (fire_h) host_addr_in = host_addr_in + 8'd1;
      if (cpu_finished_out) begin cpu_write_enable_in = 1; cpu_addr_in = cpu_addr_in + 8'd1; end
      if (bram_en_out) begin seq[got] = (bram_addr_out >= 8'd60); got++; end
    end
    cpu_write_enable_in = 0; host_valid_in = 0;
    n_cmp += 2;
    if (got != 8) begin n_bad++; $display("FAIL b2b_count: got %0d grants want 8", got); end
    if (error_out !== 1'b0) begin n_bad++; $display("FAIL b2b_error: got %b want 0", error_out); end
    for (int i = 0; i < got; i++) begin
      n_cmp++;
      if (seq[i] !== bit'(i % 2)) begin n_bad++; $display("FAIL b2b_grant i=%0d: got host=%b want host=%b", i, seq[i], i % 2); end
    end
  endtask

  task automatic test_pending_error;
    int en_cnt = 0;
    int fin_cnt = 0;
    logic [7:0] en_addr = '0;
    do_reset;
    cpu_addr_in = 8'd7; cpu_data_in = PAT_D; cpu_write_enable_in = 1;
    tick;
    n_cmp++;
    if (error_out !== 1'b0) begin n_bad++; $display("FAIL pend_err_early: got %b want 0", error_out); end
    cpu_addr_in = 8'd8;
    tick;
    cpu_write_enable_in = 0;
    if (bram_en_out) begin en_cnt++; en_addr = bram_addr_out; end
    n_cmp++;
    if (error_out !== 1'b1) begin n_bad++; $display("FAIL pend_err_set: got %b want 1", error_out); end
    for (int k = 0; k < 10; k++) begin
      tick;
      if (bram_en_out) begin en_cnt++; en_addr = bram_addr_out; end
      if (cpu_finished_out) fin_cnt++;
    end
    n_cmp += 4;
    if (en_cnt != 1) begin n_bad++; $display("FAIL pend_en_cnt: got %0d want 1", en_cnt); end
    if (fin_cnt != 1) begin n_bad++; $display("FAIL pend_fin_cnt: got %0d want 1", fin_cnt); end
    if (en_addr !== 8'd7) begin n_bad++; $display("FAIL pend_addr: got %0d want 7", en_addr); end
    if (error_out !== 1'b1) begin n_bad++; $display("FAIL pend_err_sticky: got %b want 1", error_out); end

    do_reset;
    cpu_addr_in = 8'd9; cpu_data_in = PAT_D; cpu_read_enable_in = 1; cpu_write_enable_in = 1;
    tick;
    cpu_read_enable_in = 0; cpu_write_enable_in = 0;
    tick;
    n_cmp += 2;
    if (bram_we_out !== 1'b1) begin n_bad++; $display("FAIL rdwr_we: got %b want 1", bram_we_out); end
    if (error_out !== 1'b1) begin n_bad++; $display("FAIL rdwr_err: got %b want 1", error_out); end
    tick; tick;
    n_cmp++;
    if (mem[9] !== PAT_D) begin n_bad++; $display("FAIL rdwr_mem: got %0h want %0h", mem[9][31:0], PAT_D[31:0]); end
  endtask

  task automatic test_reset_mid;
    int ev = 0;
    do_reset;
    cpu_addr_in = 8'd5; cpu_read_enable_in = 1;
    host_addr_in = 8'd20; host_we_in = 0; host_valid_in = 1;
    tick;
    cpu_read_enable_in = 0; host_valid_in = 0;
    tick;
    n_cmp++;
    if (bram_en_out !== 1'b1) begin n_bad++; $display("FAIL mid_en_pre: got %b want 1", bram_en_out); end
    tick;
    rst_in = 1;
    tick;
    rst_in = 0;
    n_cmp += 5;
    if (bram_en_out !== 1'b0) begin n_bad++; $display("FAIL mid_en: got %b want 0", bram_en_out); end
    if (bram_we_out !== 1'b0) begin n_bad++; $display("FAIL mid_we: got %b want 0", bram_we_out); end
    if (cpu_finished_out !== 1'b0) begin n_bad++; $display("FAIL mid_fin: got %b want 0", cpu_finished_out); end
    if (host_done_out !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b want 0", host_done_out); end
    if (host_ready_out !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", host_ready_out); end
    for (int k = 0; k < 8; k++) begin
      tick;
      if (bram_en_out || cpu_finished_out || host_done_out) ev++;
    end
    n_cmp++;
    if (ev != 0) begin n_bad++; $display("FAIL mid_quiet: got %0d events want 0", ev); end
  endtask

  task automatic test_out_of_range;
    logic [7:0]    addrs [4] = '{8'd199, 8'd250, 8'd199, 8'd200};
    bit            exp_en [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int            exp_k  [4] = '{4, 2, 4, 2};
    do_reset;
    for (int i = 0; i < 4; i++) begin
      bit saw_en = 0;
      int done_k = -1;
      logic [1023:0] exp_data;
      exp_data = exp_en[i] ? '1 : '0;
      n_cmp++;
      if (d2_host_ready !== 1'b1) begin n_bad++; $display("FAIL oor_ready i=%0d: got %b want 1", i, d2_host_ready); end
      d2_host_addr = addrs[i]; d2_host_we = 0; d2_host_valid = 1;
      tick;
      d2_host_valid = 0;
      for (int k = 0; k < 8; k++) begin
        if (d2_en) saw_en = 1;
        if (d2_host_done && done_k < 0) begin
          done_k = k;
          n_cmp++;
          if (d2_host_dout !== exp_data) begin n_bad++; $display("FAIL oor_data addr=%0d: got %0h want %0h", addrs[i], d2_host_dout[31:0], exp_data[31:0]); end
        end
        tick;
      end
      n_cmp += 2;
      if (saw_en !== exp_en[i]) begin n_bad++; $display("FAIL oor_en addr=%0d: got %b want %b", addrs[i], saw_en, exp_en[i]); end
      if (done_k != exp_k[i]) begin n_bad++; $display("FAIL oor_done addr=%0d: got cycle %0d want %0d", addrs[i], done_k, exp_k[i]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_cpu_write_read;
    test_simultaneous;
    test_rr_tie;
    test_back_to_back;
    test_pending_error;
    test_reset_mid;
    test_out_of_range;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
